// File: rtl/ibex_acc_arbiter_if.sv
`default_nettype none
// ============================================================================
// ibex_acc_arbiter_if : requester, accelerator and status bundle of the
// shared-accelerator arbiter. Optional id_mismatch_o with IBEX_ACC_ARB_ID_CHECK_EN.
// Revision: 1.0
// ============================================================================
interface ibex_acc_arbiter_if #(
  parameter int NumReq         = 4,
  parameter int MaxOutstanding = 4,
  parameter int ReqWidth       = 165,
  parameter int RespWidth      = 38
);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [NumReq-1:0]          req_valid_i;
  logic [NumReq-1:0]          req_ready_o;
  logic [NumReq*ReqWidth-1:0] req_i;
  logic                       acc_req_valid_o;
  logic                       acc_req_ready_i;
  logic [ReqWidth-1:0]        acc_req_o;
  logic                       acc_resp_valid_i;
  logic                       acc_resp_ready_o;
  logic [RespWidth-1:0]       acc_resp_i;
  logic [NumReq-1:0]          resp_valid_o;
  logic [NumReq-1:0]          resp_ready_i;
  logic [RespWidth-1:0]       resp_o;
  logic [CntW-1:0]            outstanding_o;
  logic                       spurious_o;
`ifdef IBEX_ACC_ARB_ID_CHECK_EN
  logic                       id_mismatch_o;
`endif

  modport slave (
    input  req_valid_i, req_i, acc_req_ready_i, acc_resp_valid_i, acc_resp_i, resp_ready_i,
`ifdef IBEX_ACC_ARB_ID_CHECK_EN
    output id_mismatch_o,
`endif
    output req_ready_o, acc_req_valid_o, acc_req_o, acc_resp_ready_o, resp_valid_o,
    output resp_o, outstanding_o, spurious_o
  );

  modport master (
    output req_valid_i, req_i, acc_req_ready_i, acc_resp_valid_i, acc_resp_i, resp_ready_i,
`ifdef IBEX_ACC_ARB_ID_CHECK_EN
    input  id_mismatch_o,
`endif
    input  req_ready_o, acc_req_valid_o, acc_req_o, acc_resp_ready_o, resp_valid_o,
    input  resp_o, outstanding_o, spurious_o
  );
endinterface
`default_nettype wire

// File: rtl/ibex_acc_arbiter.sv
`default_nettype none
// ============================================================================
// ibex_acc_arbiter : round-robin arbiter sharing one accelerator among NumReq
// requesters, in-order response routing. Option: IBEX_ACC_ARB_ID_CHECK_EN.
// Revision: 1.0
// ============================================================================
module ibex_acc_arbiter #(
  parameter int NumReq         = 4,
  parameter int MaxOutstanding = 4,
  parameter int ReqWidth       = 165,
  parameter int RespWidth      = 38
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ibex_acc_arbiter_if.slave bus
);
  localparam int IdxW = $clog2(NumReq);
  localparam int PtrW = $clog2(MaxOutstanding);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int IdW  = 5;
  // acc_req_t = {addr, id, instr, arg0, arg1, arg2}; acc_resp_t = {id, error, data}
  localparam int ReqIdLsb   = ReqWidth - 32 - IdW;
  localparam int RespIdLsb  = RespWidth - IdW;
  localparam int RespErrBit = RespIdLsb - 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return IdxW'(s);
  endfunction

  logic [ReqWidth-1:0] req_arr [NumReq];

  for (genvar k = 0; k < NumReq; k++) begin : g_unpack
    assign req_arr[k] = bus.req_i[k*ReqWidth +: ReqWidth];
  end

  logic [IdxW-1:0]     rr_q;
  logic [IdxW-1:0]     winner;
  logic [IdxW-1:0]     cand;
  logic                any_valid;
  logic                slot_valid_q;
  logic [ReqWidth-1:0] slot_q;
  logic                slot_free;
  logic                can_grant;
  logic                push;
  logic                pop;
  logic [NumReq-1:0]   req_ready;

  logic [IdxW-1:0]     fifo_idx_q [MaxOutstanding];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     cnt_q;
  logic                fifo_empty;
  logic [IdxW-1:0]     head_idx;
  logic                head_ready;
  logic [NumReq-1:0]   resp_valid;
  logic                spurious_q;

  // First valid requester at or after rr_q, wrapping modulo NumReq.
  always_comb begin
    winner    = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cand = wrap_add(rr_q, i);
      if (!any_valid && bus.req_valid_i[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  assign slot_free = !slot_valid_q || bus.acc_req_ready_i;
  assign can_grant = slot_free && (cnt_q < MaxCnt);
  assign push      = any_valid && can_grant;

  always_comb begin
    req_ready = '0;
    if (any_valid && can_grant) req_ready[winner] = 1'b1;
  end

  assign bus.req_ready_o = req_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q         <= '0;
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
    end else if (push) begin
      rr_q         <= wrap_add(winner, 1);
      slot_valid_q <= 1'b1;
      slot_q       <= req_arr[winner];
    end else if (bus.acc_req_ready_i) begin
      slot_valid_q <= 1'b0;
    end
  end

  assign bus.acc_req_valid_o = slot_valid_q;
  assign bus.acc_req_o       = slot_q;

  assign fifo_empty = (cnt_q == '0);
  assign head_idx   = fifo_idx_q[rd_ptr_q];
  assign head_ready = bus.resp_ready_i[head_idx];
  assign pop        = !fifo_empty && bus.acc_resp_valid_i && head_ready;

  always_comb begin
    resp_valid = '0;
    if (!fifo_empty) resp_valid[head_idx] = bus.acc_resp_valid_i;
  end

  assign bus.resp_valid_o = resp_valid;
  // With nothing outstanding the response is swallowed so the accelerator never stalls.
  assign bus.acc_resp_ready_o = fifo_empty ? bus.acc_resp_valid_i : head_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      spurious_q <= fifo_empty && bus.acc_resp_valid_i;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_idx_q[wr_ptr_q] <= winner;
  end

  assign bus.outstanding_o = cnt_q;
  assign bus.spurious_o    = spurious_q;

`ifdef IBEX_ACC_ARB_ID_CHECK_EN
  logic [IdW-1:0]       fifo_id_q [MaxOutstanding];
  logic                 id_bad;
  logic                 id_mismatch_q;
  logic [RespWidth-1:0] resp;

  always_ff @(posedge clk_i) begin
    if (push) fifo_id_q[wr_ptr_q] <= req_arr[winner][ReqIdLsb +: IdW];
  end

  assign id_bad = !fifo_empty && bus.acc_resp_valid_i &&
                  (bus.acc_resp_i[RespIdLsb +: IdW] != fifo_id_q[rd_ptr_q]);

  always_comb begin
    resp             = bus.acc_resp_i;
    resp[RespErrBit] = bus.acc_resp_i[RespErrBit] | id_bad;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) id_mismatch_q <= 1'b0;
    else       id_mismatch_q <= pop && id_bad;
  end

  assign bus.resp_o        = resp;
  assign bus.id_mismatch_o = id_mismatch_q;
`else
  assign bus.resp_o = bus.acc_resp_i;
`endif

endmodule
`default_nettype wire
